// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit.
// Optional build macro MD_DIV0_GUARD_EN (see md_stall_ctrl).
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Combinational 64-bit mult/div result for the HI/LO unit.
// Divide by zero yields HI = a, LO = all ones.
module md_datapath
  import md_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic               b_zero;

  assign b_zero = (b == 32'd0);

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    q_s    = 32'sd0;
    r_s    = 32'sd0;
    q_u    = 32'd0;
    r_u    = 32'd0;
    if (!b_zero) begin
      q_s = $signed(a) / $signed(b);
      r_s = $signed(a) % $signed(b);
      q_u = a / b;
      r_u = a % b;
    end
  end

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    unique case (1'b1)
      (op == MD_MULT): begin
        hi = prod_s[63:32];
        lo = prod_s[31:0];
      end
      (op == MD_MULTU): begin
        hi = prod_u[63:32];
        lo = prod_u[31:0];
      end
      (op == MD_DIV): begin
        hi = b_zero ? a : r_s;
        lo = b_zero ? 32'hFFFF_FFFF : q_s;
      end
      (op == MD_DIVU): begin
        hi = b_zero ? a : r_u;
        lo = b_zero ? 32'hFFFF_FFFF : q_u;
      end
      default: begin
        hi = 32'd0;
        lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_stall_ctrl.sv
// HI/LO multi-cycle controller: FSM, cycle counter, result regs.
// Define MD_DIV0_GUARD_EN to leave HI/LO untouched on divide by zero.
module md_stall_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_e,
  input  logic [1:0]  op_e,
  input  logic        mthi_e,
  input  logic        mtlo_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        md_use_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        m_stall
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ?
                        DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  md_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic        ld;
  logic        skip_wr;
  logic [31:0] dp_hi, dp_lo;

  md_datapath u_dp (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .hi (dp_hi),
    .lo (dp_lo)
  );

`ifdef MD_DIV0_GUARD_EN
  assign skip_wr = md_is_div(op_q) && (b_q == 32'd0);
`else
  assign skip_wr = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    ld      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_e) begin
          ld      = 1'b1;
          state_n = BUSY;
          cnt_n   = md_is_div(op_e) ? CW'(DIV_CYCLES - 1)
                                    : CW'(MULT_CYCLES - 1);
        end else begin
          if (mthi_e) hi_n = rs_e;
          if (mtlo_e) lo_n = rs_e;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (!skip_wr) begin
            hi_n = dp_hi;
            lo_n = dp_lo;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      op_q  <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (ld) begin
        op_q <= op_e;
        a_q  <= rs_e;
        b_q  <= rt_e;
      end
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state == BUSY);
  assign m_stall = md_use_d & (start_e | busy);

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed scoreboard bench for md_stall_ctrl.
// Honours MD_DIV0_GUARD_EN when computing divide-by-zero results.
module tb_md_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_e;
  logic [1:0]  op_e;
  logic        mthi_e;
  logic        mtlo_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        md_use_d;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        m_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] sb[$];

  md_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start_e  (start_e),
    .op_e     (op_e),
    .mthi_e   (mthi_e),
    .mtlo_e   (mtlo_e),
    .rs_e     (rs_e),
    .rt_e     (rt_e),
    .md_use_d (md_use_d),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .m_stall  (m_stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string       tag,
                        input logic [1:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        use_d,
                        input logic        mt_both,
                        input logic        poke_mthi,
                        input int          n,
                        input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    logic [63:0] e;
    sb.push_back({exp_hi, exp_lo});
    start_e  = 1'b1;
    op_e     = op;
    rs_e     = a;
    rt_e     = b;
    md_use_d = use_d;
    mthi_e   = mt_both;
    mtlo_e   = mt_both;
    #1;
    chk({tag, "_stall_start"}, 32'(m_stall), 32'(use_d));
    step();
    start_e = 1'b0;
    mthi_e  = 1'b0;
    mtlo_e  = 1'b0;
    rs_e    = 32'hDEAD_BEEF;
    rt_e    = 32'h0BAD_0BAD;
    cyc     = 0;
    while (busy === 1'b1 && cyc < n + 5) begin
      chk({tag, "_hold_hi"}, hi, m_hi);
      chk({tag, "_hold_lo"}, lo, m_lo);
      chk({tag, "_stall_busy"}, 32'(m_stall), 32'(use_d));
      mthi_e = poke_mthi && (cyc == 1);
      rs_e   = poke_mthi ? 32'h5A5A_5A5A : 32'hDEAD_BEEF;
      cyc++;
      step();
      mthi_e = 1'b0;
    end
    chk({tag, "_busy_len"}, 32'(cyc), 32'(n));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_stall_end"}, 32'(m_stall), 32'd0);
    e = sb.pop_front();
    chk({tag, "_hi"}, hi, e[63:32]);
    chk({tag, "_lo"}, lo, e[31:0]);
    m_hi     = e[63:32];
    m_lo     = e[31:0];
    md_use_d = 1'b0;
  endtask

  initial begin
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    reset    = 1'b1;
    start_e  = 1'b0;
    op_e     = 2'b00;
    mthi_e   = 1'b0;
    mtlo_e   = 1'b0;
    rs_e     = 32'd0;
    rt_e     = 32'd0;
    md_use_d = 1'b0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    step();
    step();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(m_stall), 32'd0);
    reset = 1'b0;

    rs_e   = 32'hAAAA_5555;
    mthi_e = 1'b1;
    step();
    mthi_e = 1'b0;
    m_hi   = 32'hAAAA_5555;
    chk("mthi_hi", hi, m_hi);
    rs_e   = 32'h0BAD_F00D;
    mtlo_e = 1'b1;
    step();
    mtlo_e = 1'b0;
    m_lo   = 32'h0BAD_F00D;
    chk("mtlo_lo", lo, m_lo);
    chk("mtlo_hi", hi, m_hi);

    run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd4, 1'b1, 1'b0,
           1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1,
           1'b0, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0,
           1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0,
           1'b0, 10, 32'd2, 32'd14);
    run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0,
           1'b0, 10, 32'd1, 32'hFFFF_FFFD);

`ifdef MD_DIV0_GUARD_EN
    z_hi = m_hi;
    z_lo = m_lo;
`else
    z_hi = 32'h1234_5678;
    z_lo = 32'hFFFF_FFFF;
`endif
    run_op("divu0", 2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0,
           1'b1, 10, z_hi, z_lo);

    start_e  = 1'b1;
    op_e     = 2'b10;
    rs_e     = 32'd100;
    rt_e     = 32'd3;
    md_use_d = 1'b1;
    step();
    start_e = 1'b0;
    step();
    step();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_stall", 32'(m_stall), 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 12; i++) step();
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);
    chk("abort_late_busy", 32'(busy), 32'd0);
    md_use_d = 1'b0;

    run_op("mult_neg", 2'b00, 32'd7, 32'hFFFF_FFFB, 1'b1, 1'b0,
           1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFDD);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
